// File: rtl/operand_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_sequencer_pkg
// Brief    : Shared types and constants for the operand fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package operand_fetch_sequencer_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 6;

    // Access modes carried in bits [7:6] of a register-flagged operand
    localparam logic [1:0] c_MODE_DIRECT = 2'b00;
    localparam logic [1:0] c_MODE_ADDR   = 2'b01;
    localparam logic [1:0] c_MODE_INDIR  = 2'b10;
    localparam logic [1:0] c_MODE_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EVAL     = 3'd1,
        S_RF_WAIT  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // optype bit 2 belongs to op1, bit 0 to op3
    function automatic logic op_is_reg(input logic [2:0] optype, input logic [1:0] idx);
        case (idx)
            2'd0:    op_is_reg = optype[2];
            2'd1:    op_is_reg = optype[1];
            default: op_is_reg = optype[0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_sequencer_if
// Brief    : Decode/execute handshakes plus register-file and data-memory
//            read ports of the operand fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface operand_fetch_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 6
);
    // decode side
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        optype;
    logic [7:0]        op1_in;
    logic [7:0]        op2_in;
    logic [7:0]        op3_in;
    // register-file read port
    logic              rf_rd_en;
    logic [REG_AW-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    // data-memory read port
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    // execute side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op1_out;
    logic [DATA_W-1:0] op2_out;
    logic [DATA_W-1:0] op3_out;
    logic              mode_err;

    // Environment view: decode, execute and the two memories
    modport master (
        output in_valid, optype, op1_in, op2_in, op3_in,
        output rf_rd_data, mem_rd_data, out_ready,
        input  in_ready, rf_rd_en, rf_rd_addr, mem_rd_en, mem_rd_addr,
        input  out_valid, op1_out, op2_out, op3_out, mode_err
    );

    // Sequencer view
    modport slave (
        input  in_valid, optype, op1_in, op2_in, op3_in,
        input  rf_rd_data, mem_rd_data, out_ready,
        output in_ready, rf_rd_en, rf_rd_addr, mem_rd_en, mem_rd_addr,
        output out_valid, op1_out, op2_out, op3_out, mode_err
    );

endinterface
`default_nettype wire

// File: rtl/operand_fetch_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module   : operand_field_decode
// Brief    : Splits one raw 8-bit operand field into immediate / mode /
//            register index and the two possible extended values.
// Revision : 1.0 - initial release
// ============================================================================
module operand_field_decode
    import operand_fetch_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              reg_flag,
    input  logic [7:0]        field,
    output logic              is_imm,
    output logic [1:0]        mode,
    output logic [REG_AW-1:0] reg_idx,
    output logic [DATA_W-1:0] imm_sext,
    output logic [DATA_W-1:0] addr_zext
);

    assign is_imm    = ~reg_flag;
    assign mode      = field[7:6];
    assign reg_idx   = field[REG_AW-1:0];
    assign imm_sext  = {{(DATA_W-8){field[7]}}, field};
    assign addr_zext = {{(DATA_W-REG_AW){1'b0}}, field[REG_AW-1:0]};

endmodule
`default_nettype wire

// File: rtl/operand_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_sequencer
// Brief    : Resolves the three operands of one decoded instruction in
//            order, sharing a single register-file and data-memory read port.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_sequencer
    import operand_fetch_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    operand_fetch_sequencer_if.slave bus
);

    state_t            r_state;
    state_t            w_nxt_state;
    logic [1:0]        r_idx;
    logic [1:0]        w_nxt_idx;
    logic [2:0]        r_optype;
    logic [7:0]        r_field1;
    logic [7:0]        r_field2;
    logic [7:0]        r_field3;
    logic [7:0]        w_field;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_op3;
    logic              r_mode_err;

    logic              w_accept;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_val;
    logic              w_set_err;
    logic              w_adv;
    logic              w_rf_en;
    logic              w_mem_en;

    logic              w_is_imm;
    logic [1:0]        w_mode;
    logic [REG_AW-1:0] w_reg_idx;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_addr_zext;

    // Field of the operand currently being resolved
    always_comb begin
        case (r_idx)
            2'd0:    w_field = r_field1;
            2'd1:    w_field = r_field2;
            default: w_field = r_field3;
        endcase
    end

    operand_field_decode #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_decode (
        .reg_flag  (op_is_reg(r_optype, r_idx)),
        .field     (w_field),
        .is_imm    (w_is_imm),
        .mode      (w_mode),
        .reg_idx   (w_reg_idx),
        .imm_sext  (w_imm_sext),
        .addr_zext (w_addr_zext)
    );

    // Next-state, read strobes and operand write-back for the current cycle
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_accept    = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_val    = '0;
        w_set_err   = 1'b0;
        w_adv       = 1'b0;
        w_rf_en     = 1'b0;
        w_mem_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid && !rst) begin
                    w_accept    = 1'b1;
                    w_nxt_state = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_is_imm) begin
                    w_wr_en  = 1'b1;
                    w_wr_val = w_imm_sext;
                    w_adv    = 1'b1;
                end else begin
                    case (w_mode)
                        c_MODE_ADDR: begin
                            w_wr_en  = 1'b1;
                            w_wr_val = w_addr_zext;
                            w_adv    = 1'b1;
                        end
                        c_MODE_RSVD: begin
                            w_wr_en   = 1'b1;
                            w_set_err = 1'b1;
                            w_adv     = 1'b1;
                        end
                        default: begin
                            w_rf_en     = 1'b1;
                            w_nxt_state = S_RF_WAIT;
                        end
                    endcase
                end
            end
            S_RF_WAIT: begin
                if (w_mode == c_MODE_INDIR) begin
                    w_mem_en    = 1'b1;
                    w_nxt_state = S_MEM_WAIT;
                end else begin
                    w_wr_en  = 1'b1;
                    w_wr_val = bus.rf_rd_data;
                    w_adv    = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                w_wr_en  = 1'b1;
                w_wr_val = bus.mem_rd_data;
                w_adv    = 1'b1;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
        // Operand completion moves straight on without a separate cycle
        if (w_adv) begin
            if (r_idx == 2'd2) begin
                w_nxt_state = S_DONE;
            end else begin
                w_nxt_idx   = r_idx + 2'd1;
                w_nxt_state = S_EVAL;
            end
        end
    end

    // State, operand index and captured instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_optype <= 3'd0;
            r_field1 <= 8'd0;
            r_field2 <= 8'd0;
            r_field3 <= 8'd0;
        end else begin
            r_state <= w_nxt_state;
            if (w_accept) begin
                r_idx    <= 2'd0;
                r_optype <= bus.optype;
                r_field1 <= bus.op1_in;
                r_field2 <= bus.op2_in;
                r_field3 <= bus.op3_in;
            end else begin
                r_idx <= w_nxt_idx;
            end
        end
    end

    // Resolved operands and error flag, cleared when a new instruction lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1      <= '0;
            r_op2      <= '0;
            r_op3      <= '0;
            r_mode_err <= 1'b0;
        end else if (w_accept) begin
            r_op1      <= '0;
            r_op2      <= '0;
            r_op3      <= '0;
            r_mode_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                case (r_idx)
                    2'd0:    r_op1 <= w_wr_val;
                    2'd1:    r_op2 <= w_wr_val;
                    default: r_op3 <= w_wr_val;
                endcase
            end
            if (w_set_err) begin
                r_mode_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE) && !rst;
    assign bus.rf_rd_en    = w_rf_en;
    assign bus.rf_rd_addr  = w_rf_en ? w_reg_idx : '0;
    assign bus.mem_rd_en   = w_mem_en;
    assign bus.mem_rd_addr = w_mem_en ? bus.rf_rd_data : '0;
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.op1_out     = r_op1;
    assign bus.op2_out     = r_op2;
    assign bus.op3_out     = r_op3;
    assign bus.mode_err    = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch_sequencer
// Brief    : Self-checking bench with register-file / memory responders and
//            a timing-aware reference model of operand resolution.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_sequencer;

    localparam int DW = 16;
    localparam int AW = 6;

    typedef struct packed {
        int          k;
        bit          is_mem;
        logic [15:0] addr;
    } strobe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   both_seen = 1'b0;

    logic [15:0] rf [0:63];
    logic [15:0] mem_ovr [logic [15:0]];
    strobe_t     exp_q [$];
    strobe_t     got_q [$];

    always #5 clk = ~clk;

    operand_fetch_sequencer_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    operand_fetch_sequencer #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Memories answer one cycle after the strobe; otherwise the bus carries junk
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rf_rd_en) bus.rf_rd_data <= rf[bus.rf_rd_addr];
        else              bus.rf_rd_data <= 16'($urandom);
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_val(bus.mem_rd_addr);
        else               bus.mem_rd_data <= 16'($urandom);
    end

    // Strobe log, stamped with the cycle number relative to acceptance
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rf_rd_en && bus.mem_rd_en) both_seen = 1'b1;
            if (bus.rf_rd_en)
                got_q.push_back('{k: cyc - acc_cyc + 1, is_mem: 1'b0, addr: {10'd0, bus.rf_rd_addr}});
            if (bus.mem_rd_en)
                got_q.push_back('{k: cyc - acc_cyc + 1, is_mem: 1'b1, addr: bus.mem_rd_addr});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: value, error flag, completion cycle and read trace of an instruction
    task automatic model(input logic [2:0] ot, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, output logic [15:0] e1, output logic [15:0] e2,
                         output logic [15:0] e3, output bit eerr, output int elat);
        logic [7:0]  f [3];
        logic [15:0] v [3];
        logic [15:0] ptr;
        int          t;
        int          r;
        f = '{a, b, c};
        t = 1;
        eerr = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            r = int'(f[i][5:0]);
            if (!ot[2-i]) begin
                v[i] = 16'($signed(f[i]));
                t += 1;
            end else begin
                case (f[i][7:6])
                    2'b01: begin v[i] = 16'(r); t += 1; end
                    2'b11: begin v[i] = 16'd0; eerr = 1'b1; t += 1; end
                    2'b00: begin
                        exp_q.push_back('{k: t, is_mem: 1'b0, addr: 16'(r)});
                        v[i] = rf[r];
                        t += 2;
                    end
                    default: begin
                        ptr = rf[r];
                        exp_q.push_back('{k: t, is_mem: 1'b0, addr: 16'(r)});
                        exp_q.push_back('{k: t + 1, is_mem: 1'b1, addr: ptr});
                        v[i] = mem_val(ptr);
                        t += 3;
                    end
                endcase
            end
        end
        e1 = v[0]; e2 = v[1]; e3 = v[2];
        elat = t;
    endtask

    task automatic run_instr(input logic [2:0] ot, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input int hold);
        logic [15:0] e1, e2, e3;
        bit          eerr;
        int          elat;
        bit          seen;
        model(ot, a, b, c, e1, e2, e3, eerr, elat);
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.optype   = ot;
        bus.op1_in   = a;
        bus.op2_in   = b;
        bus.op3_in   = c;
        got_q.delete();
        both_seen = 1'b0;
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.optype   = 3'($urandom);
        bus.op1_in   = 8'($urandom);
        bus.op2_in   = 8'($urandom);
        bus.op3_in   = 8'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("out_valid_timeout", 64'(seen), 64'd1);
        check("latency", 64'(cyc - acc_cyc + 1), 64'(elat));
        check("op1", 64'(bus.op1_out), 64'(e1));
        check("op2", 64'(bus.op2_out), 64'(e2));
        check("op3", 64'(bus.op3_out), 64'(e3));
        check("mode_err", 64'(bus.mode_err), 64'(eerr));
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
        check("one_strobe", 64'(both_seen), 64'd0);
        check("strobe_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check("strobe", 64'(got_q[i]), 64'(exp_q[i]));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_ready", 64'(bus.in_ready), 64'd0);
            check("hold_ops", {16'd0, bus.op1_out, bus.op2_out, bus.op3_out}, {16'd0, e1, e2, e3});
            check("hold_err", 64'(bus.mode_err), 64'(eerr));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", 64'(bus.out_valid), 64'd0);
        check("ready_back", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bit found;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.optype    = 3'd0;
        bus.op1_in    = 8'd0;
        bus.op2_in    = 8'd0;
        bus.op3_in    = 8'd0;
        for (int i = 0; i < 64; i++) rf[i] = 16'($urandom);
        rf[2] = 16'h0040;
        rf[3] = 16'h1234;
        rf[4] = 16'h8000;
        rf[5] = 16'h0001;
        mem_ovr[16'h0040] = 16'hBEEF;

        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_strobes", {62'd0, bus.rf_rd_en, bus.mem_rd_en}, 64'd0);
        check("rst_ops", {16'd0, bus.op1_out, bus.op2_out, bus.op3_out}, 64'd0);
        check("rst_err", 64'(bus.mode_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_instr(3'b000, 8'h05, 8'hFB, 8'h80, 0);
        run_instr(3'b111, 8'h03, 8'h04, 8'h05, 0);
        run_instr(3'b100, 8'h82, 8'h7F, 8'h01, 0);
        run_instr(3'b011, 8'h11, 8'h45, 8'hC7, 0);
        run_instr(3'b110, 8'h82, 8'h45, 8'h9C, 5);

        // Reset while the third operand waits on memory
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.optype   = 3'b001;
        bus.op1_in   = 8'h55;
        bus.op2_in   = 8'h33;
        bus.op3_in   = 8'h82;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin
                found = 1'b1;
                break;
            end
        end
        check("mem_strobe_seen", 64'(found), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_strobes", {62'd0, bus.rf_rd_en, bus.mem_rd_en}, 64'd0);
        check("midrst_ops", {16'd0, bus.op1_out, bus.op2_out, bus.op3_out}, 64'd0);
        check("midrst_err", 64'(bus.mode_err), 64'd0);
        check("midrst_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_instr(3'b001, 8'h55, 8'h33, 8'h82, 1);

        for (int n = 0; n < 150; n++) begin
            run_instr(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
